sram_rw_port_ctrl: RTL and testbench

- Initiator-side controller for a single-port masked SRAM macro with 1 RW port and 1-cycle registered-address read.
- Accepts read/write requests over valid/ready and drives the macro's addr/en/wmode/wmask/wdata.
- Captures read data one cycle after issue into a 2-entry response buffer with backpressure.
- Optionally zero-fills the whole array after reset before accepting traffic.

---
 rtl/sram_rw_pkg.sv | 20 ++
 rtl/sram_resp_fifo.sv | 50 +++++
 rtl/sram_rw_port_ctrl.sv | 114 +++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_pkg.sv
// Shared types and default widths for the masked single-port SRAM controller.
package sram_rw_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned MASK_W = 6;

  typedef enum logic [0:0] {
    INIT,
    RUN
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order read-response buffer; push and pop may coincide.
module sram_resp_fifo #(
  parameter int unsigned DATA_W = 36
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              push_ok;
  logic              pop_ok;

  assign push_ok = push && (count_q != 2'd2);
  assign pop_ok  = pop && (count_q != 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 2'd1;
      end
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Initiator-side controller for a 1RW masked SRAM with registered-address read,
// optional zero-fill sweep after reset and a credit-limited two-entry response buffer.
module sram_rw_port_ctrl #(
  parameter int unsigned ADDR_W        = sram_rw_pkg::ADDR_W,
  parameter int unsigned DATA_W        = sram_rw_pkg::DATA_W,
  parameter int unsigned MASK_W        = sram_rw_pkg::MASK_W,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [MASK_W-1:0] sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  import sram_rw_pkg::*;

  if (DATA_W % MASK_W != 0) begin : gen_mask_check
    $error("DATA_W must be a multiple of MASK_W");
  end

  localparam state_e RstState = state_e'(INIT_ON_RESET ? INIT : RUN);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q;
  logic              inflight_q, inflight_d;
  logic [1:0]        fifo_cnt;
  logic [2:0]        occupancy;
  logic              fire;
  logic              pop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= RstState;
      init_cnt_q  <= '0;
      init_done_q <= ~INIT_ON_RESET;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= (state_d == RUN);
      inflight_q  <= inflight_d;
    end
  end

  // Credit counts buffered entries plus the read whose data lands next edge,
  // less the entry being drained this cycle.
  assign pop       = resp_valid && resp_ready;
  assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
  assign req_ready = init_done_q && !reset && (occupancy < 3'd2);
  assign fire      = req_valid && req_ready;
  assign init_done = init_done_q;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    inflight_d = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    unique case (state_q)
      INIT: begin
        sram_en    = !reset;
        sram_wmode = 1'b1;
        sram_wmask = '1;
        sram_addr  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (fire) begin
          sram_en    = 1'b1;
          sram_wmode = req_write;
          sram_addr  = req_addr;
          sram_wmask = req_wmask;
          sram_wdata = req_wdata;
        end
        inflight_d = fire && !req_write;
      end
    endcase
  end

  sram_resp_fifo #(
    .DATA_W(DATA_W)
  ) u_resp_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(sram_rdata),
    .pop      (pop),
    .pop_data (resp_rdata),
    .count    (fifo_cnt)
  );

  assign resp_valid = (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Scoreboard bench: drivers queue hand-computed read data, a negedge monitor checks responses.
module tb_sram_rw_port_ctrl;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 36;
  localparam int unsigned MW = 6;
  localparam int unsigned SW = DW / MW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_wmask;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic [AW-1:0] sram_addr;
  logic          sram_en;
  logic          sram_wmode;
  logic [MW-1:0] sram_wmask;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clock = ~clock;

  sram_rw_port_ctrl #(
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .MASK_W       (MW),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .init_done (init_done),
    .sram_addr (sram_addr),
    .sram_en   (sram_en),
    .sram_wmode(sram_wmode),
    .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Behavioural macro: masked write, registered-address read.
  logic [DW-1:0] mem [2**AW];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        for (int s = 0; s < MW; s++) begin
          if (sram_wmask[s]) mem[sram_addr][s*SW +: SW] <= sram_wdata[s*SW +: SW];
        end
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: scoreboard compare on every handshake, plus hold-stability under backpressure.
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic [DW-1:0] exp_d;
  always @(negedge clock) begin
    if (reset) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && resp_valid) check("resp_hold_stable", resp_rdata, hold_d);
      hold_v = resp_valid && !resp_ready;
      hold_d = resp_rdata;
      if (resp_valid && resp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stray_resp: got data %h, expected no response", resp_rdata);
        end else begin
          exp_d = exp_q.pop_front();
          if (resp_rdata !== exp_d) begin
            errors++;
            $display("FAIL resp_data: got %h expected %h", resp_rdata, exp_d);
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the fire edge with req_valid dropped.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [MW-1:0] m, input logic [DW-1:0] exp, output int waited);
    bit fired = 1'b0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_wmask = m;
    waited    = 0;
    for (int n = 0; n < 50 && !fired; n++) begin
      @(negedge clock);
      if (req_ready) begin
        fired = 1'b1;
        if (!wr) exp_q.push_back(exp);
      end else begin
        waited++;
      end
    end
    if (!fired) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no req_ready in %0d cycles, expected accept", waited);
    end
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 2**AW; i++) begin
      @(negedge clock);
      check($sformatf("sweep_%0d", i),
            {req_ready, init_done, sram_en, sram_wmode, sram_wmask, sram_wdata, sram_addr},
            {2'b00, 2'b11, 6'h3F, 36'h0, 4'(i)});
    end
    @(negedge clock);
    check("init_done_after_sweep", {init_done, req_ready, sram_en}, 3'b110);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion by 100us, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int w;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = 1'b1;

    @(negedge clock);
    check("reset_outputs", {req_ready, resp_valid, init_done, sram_en, resp_rdata},
          {4'b0000, 36'h0});
    @(posedge clock);
    #1;
    reset = 1'b0;
    sweep_check();

    // Write then read same address on the next cycle; data due two cycles after fire.
    issue(1'b1, 4'h5, 36'hA_BCDE_F012, 6'h3F, '0, w);
    issue(1'b0, 4'h5, '0, '0, 36'hA_BCDE_F012, w);
    @(negedge clock);
    check("latency_t1_not_valid", resp_valid, 1'b0);
    @(negedge clock);
    check("latency_t2_valid", {resp_valid, resp_rdata}, {1'b1, 36'hA_BCDE_F012});
    cycles(1);

    // Partial mask: only slice 0 cleared.
    issue(1'b1, 4'h6, 36'hF_FFFF_FFFF, 6'h3F, '0, w);
    issue(1'b1, 4'h6, 36'h0, 6'h01, '0, w);
    issue(1'b0, 4'h6, '0, '0, 36'hF_FFFF_FFC0, w);
    cycles(3);

    // Backpressure: two reads accepted, third held until the consumer drains.
    resp_ready = 1'b0;
    issue(1'b0, 4'h5, '0, '0, 36'hA_BCDE_F012, w);
    check("bp_first_wait", w, 0);
    issue(1'b0, 4'h6, '0, '0, 36'hF_FFFF_FFC0, w);
    check("bp_second_wait", w, 0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 4'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("bp_ready_low_%0d", i), {req_ready, resp_valid}, 2'b01);
    end
    @(posedge clock);
    #1;
    resp_ready = 1'b1;
    @(negedge clock);
    check("bp_ready_on_release", req_ready, 1'b1);
    if (req_ready) exp_q.push_back(36'h0);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    cycles(4);

    // Throughput: prefill i+1, then eight back-to-back reads.
    for (int i = 0; i < 8; i++) issue(1'b1, 4'(i), 36'(i + 1), 6'h3F, '0, w);
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, 4'(i), '0, '0, 36'(i + 1), w);
      check($sformatf("tput_wait_%0d", i), w, 0);
    end
    cycles(4);
    check("tput_drained", exp_q.size(), 0);

    // Reset with two responses buffered.
    resp_ready = 1'b0;
    issue(1'b0, 4'h1, '0, '0, 36'h2, w);
    issue(1'b0, 4'h2, '0, '0, 36'h3, w);
    cycles(2);
    @(negedge clock);
    check("two_buffered", {resp_valid, req_ready}, 2'b10);
    @(posedge clock);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midreset_outputs", {resp_valid, sram_en, req_ready, init_done}, 4'b0000);
    resp_ready = 1'b1;
    cycles(2);
    reset = 1'b0;
    sweep_check();
    cycles(3);
    @(negedge clock);
    check("no_stale_resp", resp_valid, 1'b0);
    @(posedge clock);
    #1;

    // Array was re-zeroed by the second sweep.
    issue(1'b0, 4'h3, '0, '0, 36'h0, w);
    cycles(5);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
